// File: rtl/wb_stage.sv
// Writeback stage: MEM/WB pipeline register, result select and load alignment.
// Define WB_INSTRET_EN to add the 64-bit retired-instruction counter and port.
module wb_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_valid,
  input  logic        mem_reg_write,
  input  logic [4:0]  mem_rd,
  input  logic [1:0]  mem_result_src,
  input  logic [2:0]  mem_funct3,
  input  logic [31:0] mem_alu_result,
  input  logic [31:0] mem_read_data,
  input  logic [31:0] mem_pc_plus4,
  input  logic        hold,
  input  logic        flush,
  output logic        WE_reg,
  output logic [4:0]  A3,
  output logic [31:0] WD_reg
`ifdef WB_INSTRET_EN
  ,
  output logic [63:0] instret
`endif
);

  logic        valid;
  logic        reg_write;
  logic [4:0]  rd;
  logic [1:0]  result_src;
  logic [2:0]  funct3;
  logic [31:0] alu_result;
  logic [31:0] read_data;
  logic [31:0] pc_plus4;
  logic        wr_done;

  // wr_done marks a held instruction whose single write has already been issued
  always_ff @(posedge clk) begin
    if (rst) begin
      valid      <= 1'b0;
      reg_write  <= 1'b0;
      rd         <= 5'd0;
      result_src <= 2'b00;
      funct3     <= 3'b000;
      alu_result <= 32'd0;
      read_data  <= 32'd0;
      pc_plus4   <= 32'd0;
      wr_done    <= 1'b0;
    end else if (flush) begin
      valid   <= 1'b0;
      wr_done <= 1'b0;
    end else if (hold) begin
      if (valid) begin
        wr_done <= 1'b1;
      end
    end else begin
      valid      <= mem_valid;
      reg_write  <= mem_reg_write;
      rd         <= mem_rd;
      result_src <= mem_result_src;
      funct3     <= mem_funct3;
      alu_result <= mem_alu_result;
      read_data  <= mem_read_data;
      pc_plus4   <= mem_pc_plus4;
      wr_done    <= 1'b0;
    end
  end

  logic [7:0]  load_byte;
  logic [15:0] load_half;
  logic [31:0] load_data;

  // Little-endian lane select; halfword ignores offset bit 0
  always_comb begin
    load_byte = read_data[7:0];
    case (alu_result[1:0])
      2'd0: load_byte = read_data[7:0];
      2'd1: load_byte = read_data[15:8];
      2'd2: load_byte = read_data[23:16];
      2'd3: load_byte = read_data[31:24];
      default: load_byte = read_data[7:0];
    endcase
    load_half = alu_result[1] ? read_data[31:16] : read_data[15:0];
  end

  always_comb begin
    load_data = read_data;
    case (funct3)
      3'b000:  load_data = {{24{load_byte[7]}}, load_byte};
      3'b100:  load_data = {24'd0, load_byte};
      3'b001:  load_data = {{16{load_half[15]}}, load_half};
      3'b101:  load_data = {16'd0, load_half};
      default: load_data = read_data;
    endcase
  end

  always_comb begin
    WD_reg = alu_result;
    case (result_src)
      2'b01:   WD_reg = load_data;
      2'b10:   WD_reg = pc_plus4;
      default: WD_reg = alu_result;
    endcase
  end

  assign WE_reg = valid & reg_write & (rd != 5'd0) & ~wr_done;
  assign A3     = rd;

`ifdef WB_INSTRET_EN
  // Counts each valid instruction once, in its first WB cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      instret <= 64'd0;
    end else if (valid & ~wr_done) begin
      instret <= instret + 64'd1;
    end
  end
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Directed self-checking bench for wb_stage with hand-computed expectations.
// Instret checks are active only when WB_INSTRET_EN is defined.
module tb_wb_stage;

  logic        clk;
  logic        rst;
  logic        mem_valid;
  logic        mem_reg_write;
  logic [4:0]  mem_rd;
  logic [1:0]  mem_result_src;
  logic [2:0]  mem_funct3;
  logic [31:0] mem_alu_result;
  logic [31:0] mem_read_data;
  logic [31:0] mem_pc_plus4;
  logic        hold;
  logic        flush;
  logic        WE_reg;
  logic [4:0]  A3;
  logic [31:0] WD_reg;
`ifdef WB_INSTRET_EN
  logic [63:0] instret;
  logic [63:0] saved_instret;
`endif

  int checks = 0;
  int errors = 0;

  wb_stage dut (
    .clk            (clk),
    .rst            (rst),
    .mem_valid      (mem_valid),
    .mem_reg_write  (mem_reg_write),
    .mem_rd         (mem_rd),
    .mem_result_src (mem_result_src),
    .mem_funct3     (mem_funct3),
    .mem_alu_result (mem_alu_result),
    .mem_read_data  (mem_read_data),
    .mem_pc_plus4   (mem_pc_plus4),
    .hold           (hold),
    .flush          (flush),
    .WE_reg         (WE_reg),
    .A3             (A3),
    .WD_reg         (WD_reg)
`ifdef WB_INSTRET_EN
    ,
    .instret        (instret)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one MEM-stage vector, clock it in, then settle past the edge
  task automatic applyStimulus(input logic v, input logic rw, input logic [4:0] rdi,
                               input logic [1:0] src, input logic [2:0] f3,
                               input logic [31:0] alu, input logic [31:0] rdata,
                               input logic [31:0] pc4, input logic h, input logic f);
    mem_valid      = v;
    mem_reg_write  = rw;
    mem_rd         = rdi;
    mem_result_src = src;
    mem_funct3     = f3;
    mem_alu_result = alu;
    mem_read_data  = rdata;
    mem_pc_plus4   = pc4;
    hold           = h;
    flush          = f;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic exp_we,
                             input logic [4:0] exp_a3, input logic [31:0] exp_wd);
    checks++;
    assert (WE_reg === exp_we) else begin
      errors++;
      $error("[TB] FAIL %s WE_reg observed=%0b expected=%0b", tag, WE_reg, exp_we);
    end
    checks++;
    assert (A3 === exp_a3) else begin
      errors++;
      $error("[TB] FAIL %s A3 observed=%0d expected=%0d", tag, A3, exp_a3);
    end
    checks++;
    assert (WD_reg === exp_wd) else begin
      errors++;
      $error("[TB] FAIL %s WD_reg observed=%h expected=%h", tag, WD_reg, exp_wd);
    end
  endtask

  task automatic checkWe(input string tag, input logic exp_we);
    checks++;
    assert (WE_reg === exp_we) else begin
      errors++;
      $error("[TB] FAIL %s WE_reg observed=%0b expected=%0b", tag, WE_reg, exp_we);
    end
  endtask

`ifdef WB_INSTRET_EN
  task automatic checkInstret(input string tag, input logic [63:0] exp_cnt);
    checks++;
    assert (instret === exp_cnt) else begin
      errors++;
      $error("[TB] FAIL %s instret observed=%0d expected=%0d", tag, instret, exp_cnt);
    end
  endtask
`endif

  initial begin
    rst = 1'b1;
    // Reset for two cycles while MEM presents a valid writing instruction
    applyStimulus(1'b1, 1'b1, 5'd9, 2'b00, 3'b010, 32'h12345678, 32'h0, 32'h0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 5'd9, 2'b00, 3'b010, 32'h12345678, 32'h0, 32'h0, 1'b0, 1'b0);
    checkOutput("reset", 1'b0, 5'd0, 32'h0);
`ifdef WB_INSTRET_EN
    checkInstret("reset_instret", 64'd0);
`endif
    rst = 1'b0;

    applyStimulus(1'b1, 1'b1, 5'd10, 2'b00, 3'b010, 32'hABCDEFAB, 32'h0, 32'h0, 1'b0, 1'b0);
    checkOutput("alu_write", 1'b1, 5'd10, 32'hABCDEFAB);
    applyStimulus(1'b1, 1'b1, 5'd0, 2'b00, 3'b010, 32'hABCDEFAB, 32'h0, 32'h0, 1'b0, 1'b0);
    checkOutput("x0_write", 1'b0, 5'd0, 32'hABCDEFAB);
    applyStimulus(1'b1, 1'b1, 5'd12, 2'b11, 3'b000, 32'h0BADF00D, 32'h0, 32'h0, 1'b0, 1'b0);
    checkOutput("src11_alu", 1'b1, 5'd12, 32'h0BADF00D);
    applyStimulus(1'b1, 1'b0, 5'd13, 2'b00, 3'b000, 32'h55555555, 32'h0, 32'h0, 1'b0, 1'b0);
    checkOutput("no_regwrite", 1'b0, 5'd13, 32'h55555555);
    applyStimulus(1'b0, 1'b1, 5'd14, 2'b00, 3'b000, 32'h66666666, 32'h0, 32'h0, 1'b0, 1'b0);
    checkOutput("bubble", 1'b0, 5'd14, 32'h66666666);

    // Loads from 0x80FF7F01 at offset 2
    applyStimulus(1'b1, 1'b1, 5'd1, 2'b01, 3'b000, 32'h00001002, 32'h80FF7F01, 32'h0, 1'b0, 1'b0);
    checkOutput("lb_off2", 1'b1, 5'd1, 32'hFFFFFFFF);
    applyStimulus(1'b1, 1'b1, 5'd2, 2'b01, 3'b100, 32'h00001002, 32'h80FF7F01, 32'h0, 1'b0, 1'b0);
    checkOutput("lbu_off2", 1'b1, 5'd2, 32'h000000FF);
    applyStimulus(1'b1, 1'b1, 5'd3, 2'b01, 3'b001, 32'h00001002, 32'h80FF7F01, 32'h0, 1'b0, 1'b0);
    checkOutput("lh_off2", 1'b1, 5'd3, 32'hFFFF80FF);
    applyStimulus(1'b1, 1'b1, 5'd4, 2'b01, 3'b101, 32'h00001002, 32'h80FF7F01, 32'h0, 1'b0, 1'b0);
    checkOutput("lhu_off2", 1'b1, 5'd4, 32'h000080FF);
    applyStimulus(1'b1, 1'b1, 5'd5, 2'b01, 3'b010, 32'h00001002, 32'h80FF7F01, 32'h0, 1'b0, 1'b0);
    checkOutput("lw_off2", 1'b1, 5'd5, 32'h80FF7F01);
    // Other byte lanes, halfword with odd offset, and undefined funct3
    applyStimulus(1'b1, 1'b1, 5'd6, 2'b01, 3'b000, 32'h00001001, 32'h80FF7F01, 32'h0, 1'b0, 1'b0);
    checkOutput("lb_off1", 1'b1, 5'd6, 32'h0000007F);
    applyStimulus(1'b1, 1'b1, 5'd7, 2'b01, 3'b000, 32'h00001003, 32'h80FF7F01, 32'h0, 1'b0, 1'b0);
    checkOutput("lb_off3", 1'b1, 5'd7, 32'hFFFFFF80);
    applyStimulus(1'b1, 1'b1, 5'd8, 2'b01, 3'b100, 32'h00001000, 32'h80FF7F01, 32'h0, 1'b0, 1'b0);
    checkOutput("lbu_off0", 1'b1, 5'd8, 32'h00000001);
    applyStimulus(1'b1, 1'b1, 5'd9, 2'b01, 3'b001, 32'h00001001, 32'h80FF7F01, 32'h0, 1'b0, 1'b0);
    checkOutput("lh_off1", 1'b1, 5'd9, 32'h00007F01);
    applyStimulus(1'b1, 1'b1, 5'd11, 2'b01, 3'b101, 32'h00001003, 32'h80FF7F01, 32'h0, 1'b0, 1'b0);
    checkOutput("lhu_off3", 1'b1, 5'd11, 32'h000080FF);
    applyStimulus(1'b1, 1'b1, 5'd15, 2'b01, 3'b110, 32'h00001003, 32'h80FF7F01, 32'h0, 1'b0, 1'b0);
    checkOutput("undef_f3", 1'b1, 5'd15, 32'h80FF7F01);

    applyStimulus(1'b1, 1'b1, 5'd1, 2'b10, 3'b000, 32'hDEADBEEF, 32'h0, 32'h00000104, 1'b0, 1'b0);
    checkOutput("link", 1'b1, 5'd1, 32'h00000104);

    // Hold: the write happens only in the first WB cycle, counted once
    applyStimulus(1'b1, 1'b1, 5'd5, 2'b00, 3'b010, 32'h11111111, 32'h0, 32'h0, 1'b0, 1'b0);
    checkOutput("hold_first", 1'b1, 5'd5, 32'h11111111);
`ifdef WB_INSTRET_EN
    saved_instret = instret;
`endif
    applyStimulus(1'b1, 1'b1, 5'd20, 2'b00, 3'b010, 32'h22222222, 32'h0, 32'h0, 1'b1, 1'b0);
    checkOutput("hold_c1", 1'b0, 5'd5, 32'h11111111);
    applyStimulus(1'b1, 1'b1, 5'd20, 2'b00, 3'b010, 32'h22222222, 32'h0, 32'h0, 1'b1, 1'b0);
    checkWe("hold_c2", 1'b0);
    applyStimulus(1'b1, 1'b1, 5'd20, 2'b00, 3'b010, 32'h22222222, 32'h0, 32'h0, 1'b1, 1'b0);
    checkOutput("hold_c3", 1'b0, 5'd5, 32'h11111111);
`ifdef WB_INSTRET_EN
    checkInstret("hold_instret", saved_instret + 64'd1);
    saved_instret = instret;
`endif

    // Flush with hold and a valid capture: bubble wins
    applyStimulus(1'b1, 1'b1, 5'd7, 2'b00, 3'b010, 32'h77777777, 32'h0, 32'h0, 1'b1, 1'b1);
    checkWe("flush_hold", 1'b0);
    applyStimulus(1'b0, 1'b0, 5'd0, 2'b00, 3'b000, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
`ifdef WB_INSTRET_EN
    checkInstret("flush_instret", saved_instret);
`endif

    // Hold on a bubble must not block the next real instruction
    applyStimulus(1'b0, 1'b1, 5'd3, 2'b00, 3'b000, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, 5'd3, 2'b00, 3'b000, 32'h33333333, 32'h0, 32'h0, 1'b0, 1'b0);
    checkOutput("after_bubble_hold", 1'b1, 5'd3, 32'h33333333);

    // Reset during hold discards the instruction
    applyStimulus(1'b1, 1'b1, 5'd3, 2'b00, 3'b000, 32'h33333333, 32'h0, 32'h0, 1'b1, 1'b0);
    rst = 1'b1;
    applyStimulus(1'b1, 1'b1, 5'd3, 2'b00, 3'b000, 32'h33333333, 32'h0, 32'h0, 1'b1, 1'b0);
    checkOutput("reset_mid_hold", 1'b0, 5'd0, 32'h0);
`ifdef WB_INSTRET_EN
    checkInstret("reset_mid_hold_instret", 64'd0);
`endif
    rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
